// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // What decode sees when the buffer is empty.
    function automatic fetch_entry_t empty_entry();
        return '{pc: '0, inst: NOP_INST, fault: 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Two-entry fetch buffer with push/pop/flush; entry 0 is always the head.
module fetch_buf
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wr_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = wr_data;
                    else                 ent1_d = wr_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: shift up and refill behind the new head.
                    if (count_q == 2'd1) begin
                        ent0_d = wr_data;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= empty_entry();
            ent1_q  <= empty_entry();
            count_q <= '0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head  = (count_q == 2'd0) ? empty_entry() : ent0_q;
    assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC register, RUN/HALT control and redirect handling.
// Optional misaligned-redirect fault marker enabled by INST_FETCH_MISALIGN_CHK_EN.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] PC,
    input  logic [31:0] INST_CODE,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IF_VALID,
    input  logic        IF_READY,
    output logic [31:0] IF_INST,
    output logic [31:0] IF_PC,
    output logic        IF_FAULT
);

    logic [31:0]  pc_q, pc_d;
    fetch_state_t state_q, state_d;

    logic         push, pop, flush;
    fetch_entry_t wr_data, head;
    logic [1:0]   count;

`ifdef INST_FETCH_MISALIGN_CHK_EN
    logic         fault_pend_q, fault_pend_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
`endif

    assign pop = (count != 2'd0) && IF_READY;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        flush   = 1'b0;
        push    = 1'b0;
        wr_data = '{pc: pc_q, inst: INST_CODE, fault: 1'b0};
`ifdef INST_FETCH_MISALIGN_CHK_EN
        fault_pend_d = 1'b0;
        fault_pc_d   = fault_pc_q;
`endif
        if (REDIRECT) begin
            flush   = 1'b1;
            pc_d    = {REDIRECT_PC[31:2], 2'b00};
            state_d = RUN;
`ifdef INST_FETCH_MISALIGN_CHK_EN
            fault_pend_d = (REDIRECT_PC[1:0] != 2'b00);
            fault_pc_d   = REDIRECT_PC;
`endif
        end else if (state_q == RUN) begin
`ifdef INST_FETCH_MISALIGN_CHK_EN
            // Buffer was flushed by the redirect, so the marker always fits.
            if (fault_pend_q) begin
                push    = 1'b1;
                wr_data = '{pc: fault_pc_q, inst: NOP_INST, fault: 1'b1};
                state_d = HALT;
            end else
`endif
            if ((count != 2'd2) || pop) begin
                push = 1'b1;
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

`ifdef INST_FETCH_MISALIGN_CHK_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fault_pend_q <= 1'b0;
            fault_pc_q   <= '0;
        end else begin
            fault_pend_q <= fault_pend_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    assign IF_FAULT = head.fault;
`else
    logic unused_fault_bits;
    assign unused_fault_bits = ^{REDIRECT_PC[1:0], head.fault};
    assign IF_FAULT = 1'b0;
`endif

    fetch_buf u_buf (
        .clk     (CLK),
        .rst_n   (RESET),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .head    (head),
        .count   (count)
    );

    assign PC       = pc_q;
    assign IF_VALID = (count != 2'd0);
    assign IF_INST  = head.inst;
    assign IF_PC    = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected fetch stream modelled as address sequences.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFF8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] PC, INST_CODE;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IF_VALID, IF_READY, IF_FAULT;
    logic [31:0] IF_INST, IF_PC;

    logic [31:0] w_pc, w_inst_code, w_inst, w_if_pc;
    logic        w_valid, w_fault;
    logic        w_ready    = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redir_pc = 32'h0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    assign INST_CODE   = mem(PC);
    assign w_inst_code = mem(w_pc);

    inst_fetch #(.RESET_PC(MAIN_RESET_PC)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INST_CODE(INST_CODE),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .IF_VALID(IF_VALID), .IF_READY(IF_READY), .IF_INST(IF_INST),
        .IF_PC(IF_PC), .IF_FAULT(IF_FAULT)
    );

    inst_fetch #(.RESET_PC(WRAP_RESET_PC)) dut_wrap (
        .CLK(CLK), .RESET(RESET), .PC(w_pc), .INST_CODE(w_inst_code),
        .REDIRECT(w_redirect), .REDIRECT_PC(w_redir_pc),
        .IF_VALID(w_valid), .IF_READY(w_ready), .IF_INST(w_inst),
        .IF_PC(w_if_pc), .IF_FAULT(w_fault)
    );

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  pops   = 0;
    int           gap    = 0;
    fetch_entry_t exp_q[$];
    logic [31:0]  next_addr;
    logic [31:0]  wrap_exp;
    bit           model_halted;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void top_up();
        while (!model_halted && exp_q.size() < 8) begin
            exp_q.push_back('{pc: next_addr, inst: mem(next_addr), fault: 1'b0});
            next_addr = next_addr + 32'd4;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        next_addr    = MAIN_RESET_PC;
        model_halted = 1'b0;
        top_up();
    endfunction

    function automatic void model_redirect(input logic [31:0] tgt);
        exp_q.delete();
`ifdef INST_FETCH_MISALIGN_CHK_EN
        if (tgt[1:0] != 2'b00) begin
            exp_q.push_back('{pc: tgt, inst: NOP_INST, fault: 1'b1});
            model_halted = 1'b1;
            return;
        end
`endif
        next_addr    = tgt & 32'hFFFF_FFFC;
        model_halted = 1'b0;
        top_up();
    endfunction

    task automatic cyc();
        top_up();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            chk("reset_if_valid", 32'(IF_VALID), 32'd0);
            chk("reset_if_inst", IF_INST, NOP_INST);
            chk("reset_if_pc", IF_PC, 32'h0);
            chk("reset_if_fault", 32'(IF_FAULT), 32'd0);
            chk("reset_pc", PC, MAIN_RESET_PC);
            chk("wrap_reset_pc", w_pc, WRAP_RESET_PC);
            gap      = 2;
            wrap_exp = WRAP_RESET_PC;
        end else begin
            if (gap == 2) begin
                chk("gap_valid_low", 32'(IF_VALID), 32'd0);
                gap = 1;
            end else if (gap == 1) begin
                chk("gap_valid_high", 32'(IF_VALID), 32'd1);
                gap = 0;
            end
            if (REDIRECT) begin
                gap = 2;
            end else if (IF_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(IF_VALID), 32'd0);
                end else begin
                    chk("head_pc", IF_PC, exp_q[0].pc);
                    chk("head_inst", IF_INST, exp_q[0].inst);
                    chk("head_fault", 32'(IF_FAULT), 32'(exp_q[0].fault));
                    if (IF_READY) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
            if (w_valid) begin
                chk("wrap_if_pc", w_if_pc, wrap_exp);
                chk("wrap_if_inst", w_inst, mem(wrap_exp));
                chk("wrap_if_fault", 32'(w_fault), 32'd0);
                wrap_exp = wrap_exp + 32'd4;
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        RESET       = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = '0;
        IF_READY    = 1'b1;
        model_reset();
        repeat (2) cyc();

        // free run
        RESET = 1'b1;
        model_reset();
        repeat (6) cyc();

        // backpressure from a fresh start
        RESET = 1'b0;
        repeat (2) cyc();
        IF_READY = 1'b0;
        RESET    = 1'b1;
        model_reset();
        repeat (6) cyc();
        chk("bp_pc_hold", PC, 32'h8);
        IF_READY = 1'b1;
        repeat (5) cyc();

        // redirect while full
        IF_READY = 1'b0;
        repeat (3) cyc();
        IF_READY    = 1'b1;
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h40;
        model_redirect(32'h40);
        cyc();
        REDIRECT = 1'b0;
        repeat (4) cyc();

        // misaligned redirect, then recovery redirect
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h42;
        model_redirect(32'h42);
        cyc();
        REDIRECT = 1'b0;
        repeat (6) cyc();
`ifdef INST_FETCH_MISALIGN_CHK_EN
        chk("halt_pc_hold", PC, 32'h40);
`endif
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h80;
        model_redirect(32'h80);
        cyc();
        REDIRECT = 1'b0;
        repeat (4) cyc();

        // asynchronous reset between edges while full
        IF_READY = 1'b0;
        repeat (3) cyc();
        #2;
        RESET = 1'b0;
        #1;
        chk("async_rst_valid", 32'(IF_VALID), 32'd0);
        chk("async_rst_inst", IF_INST, NOP_INST);
        chk("async_rst_if_pc", IF_PC, 32'h0);
        chk("async_rst_fault", 32'(IF_FAULT), 32'd0);
        chk("async_rst_pc", PC, MAIN_RESET_PC);
        repeat (2) cyc();
        RESET    = 1'b1;
        IF_READY = 1'b1;
        model_reset();
        repeat (5) cyc();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            IF_READY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                tgt = $urandom;
                if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
                REDIRECT    = 1'b1;
                REDIRECT_PC = tgt;
                model_redirect(tgt);
            end else begin
                REDIRECT = 1'b0;
            end
            cyc();
        end
        REDIRECT = 1'b0;
        repeat (4) cyc();

        chk("scoreboard_activity", 32'(pops > 100), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
